// File: rtl/shift_pkg.sv
// Shared definitions for the shift execute stage.
//   - R-type funct encodings for the six supported shifts
//   - decoded op enumeration and its decode function
//   - queue entry record {result, rd, illegal}
package shift_pkg;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  typedef enum logic [2:0] {
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_ILL
  } shift_op_e;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        illegal;
  } q_entry_t;

  function automatic shift_op_e decode_funct(input logic [5:0] f);
    case (f)
      F_SLL:   return OP_SLL;
      F_SRL:   return OP_SRL;
      F_SRA:   return OP_SRA;
      F_SLLV:  return OP_SLLV;
      F_SRLV:  return OP_SRLV;
      F_SRAV:  return OP_SRAV;
      default: return OP_ILL;
    endcase
  endfunction

endpackage

// File: rtl/SHIFTER_32.sv
// 32-bit combinational barrel shifter.
//   X     : operand
//   Sa    : shift amount 0..31
//   Right : 1 = shift right, 0 = shift left
//   Arith : with Right, fill with X[31] instead of 0
//   Sh    : result
// Left shifts reuse the right-shift network by bit-reversing in and out.
module SHIFTER_32 (
  input  logic [31:0] X,
  input  logic [4:0]  Sa,
  input  logic        Right,
  input  logic        Arith,
  output logic [31:0] Sh
);

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = v[31-b];
    return r;
  endfunction

  logic        fill;
  logic [31:0] stg [6];

  assign fill   = Right & Arith & X[31];
  assign stg[0] = Right ? X : rev32(X);

  // log2 stages: stage i shifts by 2**i when Sa[i] is set
  for (genvar i = 0; i < 5; i++) begin : g_stage
    assign stg[i+1] = Sa[i] ? {{(1 << i){fill}}, stg[i][31:(1 << i)]} : stg[i];
  end

  assign Sh = Right ? stg[5] : rev32(stg[5]);

endmodule

// File: rtl/shift_exec_stage.sv
// Shift execute stage: decodes an R-type shift, computes the result
// combinationally and enqueues {result, rd, illegal} into a DEPTH-entry
// FIFO that feeds writeback.
//   clk, rst_n        : clock, synchronous active-low reset
//   flush             : synchronous queue clear (beats push/pop)
//   in_valid/in_ready : issue handshake; funct, shamt, rs, rt, rd operands
//   out_valid/out_ready : writeback handshake
//   out_data, out_rd, out_illegal : queue head, zero when empty
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [4:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  shift_op_e   op;
  logic [4:0]  sa;
  logic        right, arith, illegal;
  logic [31:0] sh;
  logic        unused_rs;

  assign op      = decode_funct(funct);
  assign illegal = (op == OP_ILL);
  assign sa      = (op == OP_SLLV || op == OP_SRLV || op == OP_SRAV) ? rs[4:0] : shamt;
  assign right   = (op == OP_SRL || op == OP_SRA || op == OP_SRLV || op == OP_SRAV);
  assign arith   = (op == OP_SRA || op == OP_SRAV);
  assign unused_rs = ^rs[31:5];

  SHIFTER_32 u_shifter (
    .X     (rt),
    .Sa    (sa),
    .Right (right),
    .Arith (arith),
    .Sh    (sh)
  );

  q_entry_t        mem_q [DEPTH];
  q_entry_t        wr_entry;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            push, pop, clr;

  assign wr_entry = '{data: illegal ? 32'd0 : sh, rd: rd, illegal: illegal};

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign clr       = !rst_n || flush;
  assign push      = in_valid && in_ready && !clr;
  assign pop       = out_valid && out_ready && !clr;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      // pointers wrap modulo DEPTH, which need not be a power of two
      if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // storage needs no reset: the head is masked whenever count is zero
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign out_data    = out_valid ? mem_q[rd_ptr_q].data    : 32'd0;
  assign out_rd      = out_valid ? mem_q[rd_ptr_q].rd      : 5'd0;
  assign out_illegal = out_valid ? mem_q[rd_ptr_q].illegal : 1'b0;

endmodule

// File: tb/tb_shift_exec_stage.sv
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [5:0]  funct;
  logic [4:0]  shamt, rd, out_rd;
  logic [31:0] rs, rt, out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_exec_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .shamt(shamt), .rs(rs), .rt(rt), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] f, input logic [4:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d);
    funct = f; shamt = s; rs = a; rt = b; rd = d; in_valid = 1'b1;
  endtask

  // SLL of 1 by s: data = 1<<s, tag d
  task automatic push_sll(input logic [4:0] s, input logic [4:0] d);
    drive(6'b000000, s, 32'd0, 32'd1, d);
  endtask

  task automatic chk_empty(input string name);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({name, "_data"}, out_data, 32'd0);
    chk({name, "_rd"}, {27'd0, out_rd}, 32'd0);
    chk({name, "_ill"}, {31'd0, out_illegal}, 32'd0);
  endtask

  task automatic chk_head(input string name, input logic [31:0] d, input logic [4:0] r);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_rd"}, {27'd0, out_rd}, {27'd0, r});
  endtask

  // fill to 2, then apply flush and/or reset with push and pop both active
  task automatic clear_case(input string name, input logic use_flush, input logic use_rst);
    @(negedge clk); push_sll(5'd1, 5'd1);
    @(negedge clk); push_sll(5'd2, 5'd2);
    @(negedge clk); push_sll(5'd3, 5'd3); out_ready = 1'b1;
    flush = use_flush; rst_n = !use_rst;
    @(negedge clk); flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    chk_empty(name);
    // pointers must be back at slot 0: a fresh item is the sole entry
    push_sll(5'd4, 5'd4);
    @(negedge clk); in_valid = 1'b0;
    chk_head({name, "_after"}, 32'h10, 5'd4);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk({name, "_after_empty"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{6'b000000, 5'd31, 32'h0,        32'h0000_0001, 5'd5,  32'h8000_0000, 1'b0};
    vecs[1]  = '{6'b000111, 5'd0,  32'hFFFF_FFE4, 32'h8000_00F0, 5'd6,  32'hF800_000F, 1'b0};
    vecs[2]  = '{6'b000110, 5'd0,  32'hFFFF_FFE4, 32'h8000_00F0, 5'd7,  32'h0800_000F, 1'b0};
    vecs[3]  = '{6'b000010, 5'd4,  32'h0,        32'hF000_0000, 5'd8,  32'h0F00_0000, 1'b0};
    vecs[4]  = '{6'b000011, 5'd4,  32'h0,        32'hF000_0000, 5'd9,  32'hFF00_0000, 1'b0};
    vecs[5]  = '{6'b000100, 5'd3,  32'h0000_0028, 32'h0000_00FF, 5'd10, 32'h0000_FF00, 1'b0};
    vecs[6]  = '{6'b100000, 5'd3,  32'h1,        32'hFFFF_FFFF, 5'd17, 32'h0,         1'b1};
    vecs[7]  = '{6'b000000, 5'd0,  32'h0,        32'h1234_5678, 5'd11, 32'h1234_5678, 1'b0};
    vecs[8]  = '{6'b000011, 5'd31, 32'h0,        32'h8000_0000, 5'd12, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{6'b000010, 5'd31, 32'h0,        32'h8000_0000, 5'd13, 32'h0000_0001, 1'b0};
    vecs[10] = '{6'b000001, 5'd2,  32'h0,        32'h0000_0003, 5'd31, 32'h0,         1'b1};
    vecs[11] = '{6'b000011, 5'd4,  32'h0,        32'h7000_0000, 5'd14, 32'h0700_0000, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(6'b0, 5'd0, 32'd0, 32'd0, 5'd0); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_empty("reset");
    rst_n = 1'b1;

    // single items through an empty queue: visible one edge after the push
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].funct, vecs[i].shamt, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      @(negedge clk); in_valid = 1'b0;
      chk_head($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].rd);
      chk($sformatf("vec%0d_ill", i), {31'd0, out_illegal}, {31'd0, vecs[i].exp_ill});
      out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
      chk($sformatf("vec%0d_popped", i), {31'd0, out_valid}, 32'd0);
    end

    // backpressure: third push rejected, head stable, order kept
    @(negedge clk); push_sll(5'd1, 5'd1);
    @(negedge clk); chk("bp_ready1", {31'd0, in_ready}, 32'd1); push_sll(5'd2, 5'd2);
    @(negedge clk); chk("bp_ready2", {31'd0, in_ready}, 32'd0); push_sll(5'd3, 5'd3);
    @(negedge clk); chk("bp_ready3", {31'd0, in_ready}, 32'd0);
    chk_head("bp_head_stable", 32'h2, 5'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); chk_head("bp_second", 32'h4, 5'd2);
    @(negedge clk); out_ready = 1'b0;
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // full queue, push pending, pop active: push blocked, then accepted
    @(negedge clk); push_sll(5'd1, 5'd1);
    @(negedge clk); push_sll(5'd2, 5'd2);
    @(negedge clk); push_sll(5'd3, 5'd3); out_ready = 1'b1;
    chk("full_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk_head("full_pop1", 32'h4, 5'd2);
    chk("full_ready_rise", {31'd0, in_ready}, 32'd1);
    @(negedge clk); in_valid = 1'b0;
    chk_head("full_pushC", 32'h8, 5'd3);
    @(negedge clk); out_ready = 1'b0;
    chk("full_drained", {31'd0, out_valid}, 32'd0);

    clear_case("flush", 1'b1, 1'b0);
    clear_case("rst", 1'b0, 1'b1);
    clear_case("rst_flush", 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
SHIFT_EXEC_STAGE -- requirements
Module: shift_exec_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2: output queue entries, legal range 2..8.
REQ-002 SHALL have port clk  input  1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-004 SHALL have port flush  input  1: synchronous queue clear.
REQ-005 SHALL have port in_valid  input  1: issue request valid.
REQ-006 SHALL have port in_ready  output  1: stage can accept an issue this cycle.
REQ-007 SHALL have port funct  input  6: R-type function code.
REQ-008 SHALL have port shamt  input  5: immediate shift amount.
REQ-009 SHALL have port rs  input  32: variable-shift source; only bits [4:0] used.
REQ-010 SHALL have port rt  input  32: operand to shift.
REQ-011 SHALL have port rd  input  5: destination register tag.
REQ-012 SHALL have port out_valid  output  1: queue head valid.
REQ-013 SHALL have port out_ready  input  1: writeback accepts the head.
REQ-014 SHALL have port out_data  output  32: shifted result at head.
REQ-015 SHALL have port out_rd  output  5: destination tag at head.
REQ-016 SHALL have port out_illegal  output  1: head came from an unsupported funct.

Function
REQ-017 SHALL decode funct: 000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV.
REQ-018 SHALL take the amount from shamt for SLL/SRL/SRA and from rs[4:0] for the V forms.
REQ-019 SHALL set Right for SRL/SRA/SRLV/SRAV and Arith only for SRA/SRAV.
REQ-020 SHALL, for any other funct, enqueue out_data=0, out_illegal=1, and the given rd.
REQ-021 SHALL perform a push when in_valid and in_ready are both high, storing {result, rd, illegal}.
REQ-022 SHALL perform a pop when out_valid and out_ready are both high.
REQ-023 SHALL drive in_ready = (count < DEPTH), which is combinational from registered count only.
REQ-024 SHALL have a latency of exactly 1 cycle: an item pushed at edge N is visible on out_* after edge N when the queue was empty.
REQ-025 SHALL keep out_* stable while out_valid=1 and out_ready=0.
REQ-026 SHALL preserve FIFO order; simultaneous push and pop leaves count unchanged and wraps the pointers modulo DEPTH.
REQ-027 SHALL, when count=DEPTH and out_ready=1, pop but not push; in_ready stays low that cycle.
REQ-028 SHALL, on flush=1, empty the queue at the edge and ignore that cycle's push and pop; flush has priority over both.
REQ-029 SHALL drive out_valid = (count != 0); out_data, out_rd and out_illegal are 0 when empty.

Reset
REQ-030 SHALL, when rst_n=0 at an edge, clear count and pointers to 0 and discard any push or pop in that cycle.
REQ-031 SHALL show in_ready=1, out_valid=0, out_data=0, out_rd=0, out_illegal=0 after reset.
REQ-032 SHALL give reset priority over flush, with an identical effect.

Structure
REQ-033 SHALL place the funct encodings and the decoded op enumeration in a shared package, shift_pkg.
REQ-034 SHALL instantiate exactly one sub-module: the existing 32-bit barrel shifter SHIFTER_32 (X=rt, Sa, Right, Arith, Sh).
REQ-035 SHALL keep the shifter combinational in front of the queue write port, with no extra pipeline register.

Verification
REQ-036 SHALL verify that SLL with rt=0x0000_0001 and shamt=31 gives out_data=0x8000_0000 one cycle after the push.
REQ-037 SHALL verify that SRAV with rt=0x8000_00F0 and rs=0xFFFF_FFE4 (amount 4) gives out_data=0xF800_000F, and that SRLV with the same operands gives 0x0800_000F.
REQ-038 SHALL verify that 3 pushes with out_ready=0 (DEPTH=2) leave in_ready=0 after the 2nd push, the 3rd is not accepted, and draining returns the items in order.
REQ-039 SHALL verify that with a full queue and in_valid=1, out_ready=1 pops the head, blocks the push, and in_ready rises the next cycle.
REQ-040 SHALL verify that funct=100000 pushes out_illegal=1, out_data=0, and rd passes through.
REQ-041 SHALL verify that flush or rst_n=0 asserted with count=2 and push and pop both active gives out_valid=0 and count=0 the next cycle.
